// File: rtl/etroc_frame_builder_if.sv
// Readout stream from the frame builder FIFO to the DAQ consumer.
// Master drives the tagged word and valid; slave answers with ready.
interface etroc_frame_builder_if;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;

  modport master (
    output outData,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    output outReady
  );
endinterface

// File: rtl/etroc_frame_builder.sv
// Classifies descrambled ETROC frames, tracks events and queues tagged words in a show-ahead FIFO.
// Optional macro FRAME_STATS_EN adds the eventCount/hitCount statistics registers.
module etroc_frame_builder #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   synched,
  input  logic [29:0]            dataIn,
  etroc_frame_builder_if.master  out_if,
  output logic                   inEvent,
  output logic [3:0]             errSticky,
  input  logic                   errClear,
  output logic [15:0]            eventCount,
  output logic [23:0]            hitCount
);

  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [0:0] {StIdle, StEvent} state_e;

  logic [29:0]        s1_data_q;
  logic               s1_synched_q;
  state_e             state_q;
  logic [7:0]         hit_cnt_q;
  logic [3:0]         err_q;
  logic [31:0]        mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   count_q;

  logic [1:0] frame_type;
  logic       is_hdr;
  logic       is_dat;
  logic       is_trl;
  logic       in_evt;
  logic       wr_req;
  logic       fifo_full;
  logic       fifo_rd;
  logic       fifo_wr;
  logic       fifo_valid;
  logic [3:0] err_set;
  logic [7:0] hit_cnt_inc;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s1_data_q    <= '0;
      s1_synched_q <= 1'b0;
    end else begin
      s1_data_q    <= dataIn;
      s1_synched_q <= synched;
    end
  end

  always_comb begin
    frame_type  = s1_data_q[29:28];
    is_hdr      = (frame_type == 2'b10);
    is_dat      = (frame_type == 2'b11);
    is_trl      = (frame_type == 2'b01);
    in_evt      = (state_q == StEvent);
    hit_cnt_inc = (hit_cnt_q == 8'hFF) ? 8'hFF : hit_cnt_q + 8'd1;

    // A header is always written; data and trailers only inside an event.
    wr_req     = s1_synched_q & (is_hdr | (in_evt & (is_dat | is_trl)));
    fifo_valid = (count_q != '0);
    fifo_full  = count_q[FIFO_AW];
    fifo_rd    = fifo_valid & out_if.outReady;
    fifo_wr    = wr_req & (~fifo_full | fifo_rd);

    err_set    = '0;
    err_set[0] = wr_req & fifo_full & ~fifo_rd;
    err_set[1] = s1_synched_q & in_evt & is_trl & (hit_cnt_q != s1_data_q[7:0]);
    err_set[2] = s1_synched_q & ((~in_evt & (is_dat | is_trl)) | (in_evt & is_hdr));
    err_set[3] = ~s1_synched_q & in_evt;
  end

  // Event FSM; state and hit count advance even when the FIFO drops the frame.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      hit_cnt_q <= '0;
    end else if (!s1_synched_q) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_hdr) begin
            state_q   <= StEvent;
            hit_cnt_q <= '0;
          end
        end
        StEvent: begin
          if (is_hdr) begin
            hit_cnt_q <= '0;
          end else if (is_dat) begin
            hit_cnt_q <= hit_cnt_inc;
          end else if (is_trl) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      err_q <= '0;
    end else if (errClear) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_q[wptr_q] <= {frame_type, s1_data_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_wr) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (fifo_rd) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (fifo_wr && !fifo_rd) begin
        count_q <= count_q + 1'b1;
      end else if (!fifo_wr && fifo_rd) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign out_if.outValid = fifo_valid;
  assign out_if.outData  = fifo_valid ? mem_q[rptr_q] : '0;
  assign inEvent         = in_evt;
  assign errSticky       = err_q;

`ifdef FRAME_STATS_EN
  logic        trl_done;
  logic        dat_acc;
  logic [15:0] event_count_q;
  logic [23:0] hit_count_q;

  assign trl_done = s1_synched_q & in_evt & is_trl;
  assign dat_acc  = s1_synched_q & in_evt & is_dat;

  always_ff @(posedge CLK) begin
    if (!RSTn || errClear) begin
      event_count_q <= '0;
      hit_count_q   <= '0;
    end else begin
      if (trl_done) begin
        event_count_q <= event_count_q + 16'd1;
      end
      if (dat_acc) begin
        hit_count_q <= hit_count_q + 24'd1;
      end
    end
  end

  assign eventCount = event_count_q;
  assign hitCount   = hit_count_q;
`else
  assign eventCount = '0;
  assign hitCount   = '0;
`endif

endmodule

// File: tb/tb_etroc_frame_builder.sv
// Bench for etroc_frame_builder: directed scenarios plus random traffic against a queue model.
module tb_etroc_frame_builder;

`ifdef FRAME_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        synched = 1'b0;
  logic        errClear = 1'b0;
  logic        rdy = 1'b0;
  logic [29:0] dataIn = '0;
  logic        inEvent;
  logic [3:0]  errSticky;
  logic [15:0] eventCount;
  logic [23:0] hitCount;

  always #5 CLK = ~CLK;

  etroc_frame_builder_if bus ();
  assign bus.outReady = rdy;

  etroc_frame_builder #(.FIFO_AW(4)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .synched    (synched),
    .dataIn     (dataIn),
    .out_if     (bus),
    .inEvent    (inEvent),
    .errSticky  (errSticky),
    .errClear   (errClear),
    .eventCount (eventCount),
    .hitCount   (hitCount)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: queue of words the consumer should see, plus event bookkeeping.
  logic [31:0] q[$];
  logic [31:0] got[$];
  bit          m_sync = 1'b0;
  logic [29:0] m_data = '0;
  bit          m_ev = 1'b0;
  int          m_hit = 0;
  logic [3:0]  m_err = '0;
  logic [15:0] m_evt = '0;
  logic [23:0] m_hits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] set;
    bit         wr;
    bit         rd;
    logic [1:0] t;
    if (!RSTn) begin
      q.delete();
      m_sync = 1'b0;
      m_data = '0;
      m_ev   = 1'b0;
      m_hit  = 0;
      m_err  = '0;
      m_evt  = '0;
      m_hits = '0;
      return;
    end
    set = '0;
    wr  = 1'b0;
    t   = m_data[29:28];
    if (m_sync) begin
      if (t == 2'b10) begin
        if (m_ev) set[2] = 1'b1;
        wr    = 1'b1;
        m_hit = 0;
        m_ev  = 1'b1;
      end else if (t == 2'b11) begin
        if (m_ev) begin
          wr     = 1'b1;
          m_hit  = (m_hit >= 255) ? 255 : m_hit + 1;
          m_hits = m_hits + 24'd1;
        end else begin
          set[2] = 1'b1;
        end
      end else if (t == 2'b01) begin
        if (m_ev) begin
          wr = 1'b1;
          if (m_hit != int'(m_data[7:0])) set[1] = 1'b1;
          m_evt = m_evt + 16'd1;
          m_ev  = 1'b0;
        end else begin
          set[2] = 1'b1;
        end
      end
    end else if (m_ev) begin
      set[3] = 1'b1;
      m_ev   = 1'b0;
    end
    rd = (q.size() != 0) && rdy;
    if (rd) void'(q.pop_front());
    if (wr) begin
      if (q.size() < 16) q.push_back({t, m_data});
      else set[0] = 1'b1;
    end
    if (errClear) begin
      m_err  = '0;
      m_evt  = '0;
      m_hits = '0;
    end else begin
      m_err = m_err | set;
    end
    m_sync = synched;
    m_data = dataIn;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("outValid", {31'd0, bus.outValid}, {31'd0, q.size() != 0});
      check("outData", bus.outData, (q.size() != 0) ? q[0] : 32'd0);
      check("inEvent", {31'd0, inEvent}, {31'd0, m_ev});
      check("errSticky", {28'd0, errSticky}, {28'd0, m_err});
      check("eventCount", {16'd0, eventCount}, StatsEn ? {16'd0, m_evt} : 32'd0);
      check("hitCount", {8'd0, hitCount}, StatsEn ? {8'd0, m_hits} : 32'd0);
      if (bus.outValid && rdy) got.push_back(bus.outData);
    end
  end

  task automatic step(input logic s, input logic [29:0] d, input logic r);
    synched = s;
    dataIn  = d;
    rdy     = r;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic fill(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, 30'd0, r);
  endtask

  task automatic clr();
    errClear = 1'b1;
    step(1'b1, 30'd0, 1'b1);
    errClear = 1'b0;
  endtask

  function automatic logic [29:0] hdr(input logic [27:0] p);
    return {2'b10, p};
  endfunction

  function automatic logic [29:0] dat(input logic [27:0] p);
    return {2'b11, p};
  endfunction

  function automatic logic [29:0] trl(input logic [7:0] n);
    return {2'b01, 20'hA5A5A, n};
  endfunction

  logic [1:0]  exp_tags [5];
  logic [31:0] exp_w [16];

  initial begin
    exp_tags = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01};

    // Reset
    step(1'b0, 30'd0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 30'd0, 1'b0);
    RSTn = 1'b1;
    check("rst_valid", {31'd0, bus.outValid}, 32'd0);
    check("rst_data", bus.outData, 32'd0);
    check("rst_err", {28'd0, errSticky}, 32'd0);
    check("rst_inev", {31'd0, inEvent}, 32'd0);
    fill(2, 1'b1);

    // Normal event and two-cycle latency
    got.delete();
    step(1'b1, hdr(28'h0000123), 1'b1);
    check("lat_not_yet", {31'd0, bus.outValid}, 32'd0);
    step(1'b1, dat(28'h0000001), 1'b1);
    check("lat_valid", {31'd0, bus.outValid}, 32'd1);
    check("lat_tag", {30'd0, bus.outData[31:30]}, 32'd2);
    check("hdr_inev", {31'd0, inEvent}, 32'd1);
    step(1'b1, dat(28'h0000002), 1'b1);
    step(1'b1, dat(28'h0000003), 1'b1);
    step(1'b1, trl(8'd3), 1'b1);
    fill(3, 1'b1);
    check("norm_count", got.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check("norm_tag", {30'd0, got[i][31:30]}, {30'd0, exp_tags[i]});
    end
    check("norm_err", {28'd0, errSticky}, 32'd0);
    check("norm_evt", {16'd0, eventCount}, StatsEn ? 32'd1 : 32'd0);
    check("norm_hits", {8'd0, hitCount}, StatsEn ? 32'd3 : 32'd0);
    check("norm_inev", {31'd0, inEvent}, 32'd0);

    // Hit-count mismatch
    clr();
    got.delete();
    step(1'b1, hdr(28'h0000010), 1'b1);
    step(1'b1, dat(28'h0000011), 1'b1);
    step(1'b1, dat(28'h0000012), 1'b1);
    step(1'b1, trl(8'd5), 1'b1);
    fill(3, 1'b1);
    check("mis_err1", {31'd0, errSticky[1]}, 32'd1);
    check("mis_count", got.size(), 32'd4);
    clr();
    check("mis_clear", {28'd0, errSticky}, 32'd0);

    // Overflow
    got.delete();
    exp_w[0] = {2'b10, hdr(28'h0000020)};
    step(1'b1, hdr(28'h0000020), 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (i < 16) exp_w[i] = {2'b11, dat(28'(i))};
      step(1'b1, dat(28'(i)), 1'b0);
    end
    step(1'b1, trl(8'd20), 1'b0);
    fill(3, 1'b0);
    check("ovf_held", got.size(), 32'd0);
    check("ovf_valid", {31'd0, bus.outValid}, 32'd1);
    check("ovf_err0", {31'd0, errSticky[0]}, 32'd1);
    fill(20, 1'b1);
    check("ovf_count", got.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got.size()) check("ovf_word", got[i], exp_w[i]);
    end
    clr();

    // Protocol errors
    got.delete();
    step(1'b1, dat(28'h0000030), 1'b1);
    fill(2, 1'b1);
    check("orphan_err2", {31'd0, errSticky[2]}, 32'd1);
    check("orphan_none", got.size(), 32'd0);
    clr();
    step(1'b1, hdr(28'h0000040), 1'b1);
    step(1'b1, hdr(28'h0000041), 1'b1);
    step(1'b1, trl(8'd0), 1'b1);
    fill(3, 1'b1);
    check("dblhdr_count", got.size(), 32'd3);
    check("dblhdr_err2", {31'd0, errSticky[2]}, 32'd1);
    check("dblhdr_evt", {16'd0, eventCount}, StatsEn ? 32'd1 : 32'd0);
    clr();

    // Sync loss mid-event
    step(1'b1, hdr(28'h0000050), 1'b1);
    step(1'b1, dat(28'h0000051), 1'b1);
    step(1'b0, dat(28'h0000052), 1'b1);
    step(1'b0, dat(28'h0000053), 1'b1);
    check("sync_err3", {31'd0, errSticky[3]}, 32'd1);
    check("sync_inev", {31'd0, inEvent}, 32'd0);
    step(1'b1, trl(8'd0), 1'b1);
    fill(2, 1'b1);
    check("sync_err2", {31'd0, errSticky[2]}, 32'd1);
    clr();
    fill(2, 1'b1);

    // Reset with 8 words queued
    step(1'b1, hdr(28'h0000060), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, dat(28'(i)), 1'b0);
    fill(2, 1'b0);
    check("rst8_queued", {31'd0, bus.outValid}, 32'd1);
    RSTn = 1'b0;
    step(1'b1, 30'd0, 1'b0);
    RSTn = 1'b1;
    check("rst8_valid", {31'd0, bus.outValid}, 32'd0);
    check("rst8_data", bus.outData, 32'd0);
    check("rst8_err", {28'd0, errSticky}, 32'd0);
    check("rst8_inev", {31'd0, inEvent}, 32'd0);
    check("rst8_evt", {16'd0, eventCount}, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [29:0] f;
      int          r;
      RSTn     = ($urandom_range(0, 599) != 0);
      errClear = ($urandom_range(0, 39) == 0);
      r        = $urandom_range(0, 9);
      f        = 30'($urandom);
      if (r < 2)      f = hdr(f[27:0]);
      else if (r < 7) f = dat(f[27:0]);
      else if (r < 8) f = trl(8'($urandom_range(0, 6)));
      else            f = 30'd0;
      step(($urandom_range(0, 49) != 0), f, ($urandom_range(0, 9) < 7));
    end
    RSTn     = 1'b1;
    errClear = 1'b0;
    fill(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/etroc_frame_builder.md
# etroc_frame_builder

Consumes the 30-bit descrambled frames produced by the frame-sync/descrambler stage and classifies each one as header, hit data, trailer or filler. It tracks event boundaries and checks the hit count in each trailer. Valid frames are pushed, tagged, into a 16-deep show-ahead FIFO that the DAQ readout drains through a valid/ready handshake. It sits between the GTX frame synchroniser and the readout/memory-write logic.

## Interface
- Parameters:
- FIFO_AW, 4, FIFO address width (depth = 2^FIFO_AW = 16)
- Ports:
- CLK  in  1  single clock, all logic on rising edge
- RSTn  in  1  reset, synchronous, active-low
- synched  in  1  frame alignment valid from the sync stage; frames ignored while 0
- dataIn  in  30  descrambled frame, one per CLK
- outData  out  32  {tag[1:0], frame[29:0]}; tag 10 = header, 11 = data, 01 = trailer
- outValid  out  1  FIFO not empty
- outReady  in  1  consumer accepts outData when outValid&outReady
- inEvent  out  1  high between an accepted header and its trailer
- errSticky  out  4  [0] FIFO overflow, [1] hit-count mismatch, [2] protocol (orphan data/trailer or header inside event), [3] sync lost mid-event
- errClear  in  1  clears errSticky (and stats counters when compiled in)
- eventCount  out  16  completed events (FRAME_STATS_EN)
- hitCount  out  24  accepted data frames (FRAME_STATS_EN)

## Operation
- Frame type is dataIn[29:28]: 10 header, 11 data, 01 trailer, 00 filler. Filler is always discarded.
- Trailer frame bits [7:0] hold the expected hit count of the event.
- Input stage: dataIn and synched are registered once (stage S1). All classification uses S1.
- FSM, two states:
- IDLE: header -> write it, clear hitCnt, go to EVENT. Data or trailer -> discard, set err[2].
- EVENT: data -> write it, hitCnt+1 (8-bit, saturates at 255). Trailer -> write it; if hitCnt != trailer[7:0], set err[1]; eventCount+1; go to IDLE. Header -> set err[2], write the new header, clear hitCnt, stay in EVENT (the previous event is abandoned).
- S1 synched=0: no writes. If in EVENT, set err[3] and go to IDLE.
- FIFO: 16×32, show-ahead, so outData is valid whenever outValid=1.
- A write while full (and no simultaneous read) drops the frame and sets err[0]. FSM state and hitCnt still update as if the frame had been written.
- Simultaneous read and write when full: both succeed, no overflow.
- The FIFO and all counters wrap with binary modular arithmetic. hitCount and eventCount wrap at 2^24 and 2^16.
- errClear has priority over a same-cycle error set: the cleared bit reads 0 for one cycle. An error occurring in a later cycle sets it again.
- inEvent = (state == EVENT).

## Timing
- Reset values: state IDLE, FIFO empty, outValid=0, outData=0, inEvent=0, errSticky=0, eventCount=0, hitCount=0.
- Latency: a frame present on dataIn at edge N is registered at N. It is written to the FIFO at edge N+1. With the FIFO empty, outValid=1 and outData is valid after edge N+1 (2 cycles).
- inEvent rises after the edge that writes the header and falls after the edge that writes the trailer.
- Throughput: one frame in per cycle, one frame out per cycle when outReady=1.
- outData is held stable while outValid=1 and outReady=0.
- Reset mid-operation: synchronous flush. All state returns to reset values on the first CLK edge with RSTn=0, and frames in flight are lost.

## Configuration
- FRAME_STATS_EN defined: the eventCount and hitCount registers are implemented and cleared by errClear.
- FRAME_STATS_EN undefined: eventCount and hitCount are tied to 0 and no counter logic is generated. Error checking, including the 8-bit per-event hitCnt, is unaffected.

## Test plan
- Normal event: synched=1; header, 3 data, trailer[7:0]=3, filler, with outReady=1. The out stream is 5 words with tags 10,11,11,11,01, the first arriving 2 cycles after the header. errSticky=0, eventCount=1, hitCount=3.
- Count mismatch: header, 2 data, trailer with count 5 -> err[1]=1, all 4 frames delivered. errClear pulse -> errSticky=0.
- Overflow: outReady=0; header, 20 data, trailer -> 16 words held, err[0]=1. Release outReady: the first 16 frames come out in order, later frames are absent.
- Protocol: a data frame while IDLE -> err[2]=1, no output. Header, header, trailer(0) -> err[2]=1, 3 words delivered, eventCount=1.
- Sync loss: header, 1 data, then synched=0 for 2 cycles -> err[3]=1, inEvent=0. A trailer after resync sets err[2].
- Reset mid-stream: RSTn=0 for one cycle with 8 words queued -> next cycle outValid=0, all outputs at reset values.
